// File: rtl/delay_line_prog.sv
// Per-channel programmable delay line. Delay changes are held pending until every
// channel's shift register is flat, so a switch never drops or duplicates a transition.
module delay_line_prog #(
  parameter int CH        = 4,
  parameter int DEPTH     = 16,
  parameter int RST_DELAY = 12,
  localparam int DW       = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] inR,
  output logic [CH-1:0] outR,
  input  logic [DW-1:0] cfg_delay,
  input  logic          cfg_we,
  output logic          cfg_pending,
  output logic          cfg_ack,
  output logic [DW-1:0] cur_delay
);

  typedef enum logic {IDLE, PEND} state_t;

  state_t           state_q, state_d;
  logic [DW-1:0]    pend_val_q, pend_val_d;
  logic [DW-1:0]    cur_delay_q, cur_delay_d;
  logic             ack_q, ack_d;
  logic [DEPTH-1:0] stg_q [CH];
  logic [DEPTH-1:0] stg_d [CH];
  logic             quiescent;
  logic [DW-1:0]    clamp_val;

  assign clamp_val = (cfg_delay > DW'(DEPTH)) ? DW'(DEPTH) : cfg_delay;

  always_comb begin
    for (int c = 0; c < CH; c++) begin
      stg_d[c]    = stg_q[c];
      stg_d[c][0] = inR[c];
      for (int i = 1; i < DEPTH; i++) stg_d[c][i] = stg_q[c][i-1];
    end
  end

  // Quiet when no channel has a transition anywhere in its shift register.
  always_comb begin
    quiescent = 1'b1;
    for (int c = 0; c < CH; c++)
      if (stg_q[c] != {DEPTH{inR[c]}}) quiescent = 1'b0;
  end

  // Delay 0 falls through as a combinational bypass.
  always_comb begin
    outR = inR;
    for (int c = 0; c < CH; c++)
      for (int i = 0; i < DEPTH; i++)
        if (cur_delay_q == DW'(i + 1)) outR[c] = stg_q[c][i];
  end

  always_comb begin
    state_d     = state_q;
    pend_val_d  = pend_val_q;
    cur_delay_d = cur_delay_q;
    ack_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_we) begin
          pend_val_d = clamp_val;
          state_d    = PEND;
        end
      end
      PEND: begin
        if (cfg_we) begin
          pend_val_d = clamp_val;
        end else if (quiescent) begin
          cur_delay_d = pend_val_q;
          state_d     = IDLE;
          ack_d       = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      pend_val_q  <= '0;
      cur_delay_q <= DW'(RST_DELAY);
      ack_q       <= 1'b0;
      for (int c = 0; c < CH; c++) stg_q[c] <= '0;
    end else begin
      state_q     <= state_d;
      pend_val_q  <= pend_val_d;
      cur_delay_q <= cur_delay_d;
      ack_q       <= ack_d;
      for (int c = 0; c < CH; c++) stg_q[c] <= stg_d[c];
    end
  end

  assign cfg_pending = (state_q == PEND);
  assign cfg_ack     = ack_q;
  assign cur_delay   = cur_delay_q;

endmodule

// File: tb/tb_delay_line_prog.sv
// Bench for delay_line_prog: directed scenarios plus random traffic, all checked
// against an input-history model of the delay line and its apply-when-quiet rule.
module tb_delay_line_prog;
  localparam int CH        = 4;
  localparam int DEPTH     = 16;
  localparam int RST_DELAY = 12;
  localparam int DW        = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst, cfg_we, cfg_pending, cfg_ack;
  logic [CH-1:0] inR, outR;
  logic [DW-1:0] cfg_delay, cur_delay;

  int total = 0;
  int bad   = 0;

  delay_line_prog #(.CH(CH), .DEPTH(DEPTH), .RST_DELAY(RST_DELAY)) dut (
    .clk(clk), .rst(rst), .inR(inR), .outR(outR),
    .cfg_delay(cfg_delay), .cfg_we(cfg_we), .cfg_pending(cfg_pending),
    .cfg_ack(cfg_ack), .cur_delay(cur_delay)
  );

  always #5 clk = ~clk;

  // Model: m_hist[k] is the inR sampled k+1 edges ago.
  logic [CH-1:0] m_hist [DEPTH];
  int            m_cur  = RST_DELAY;
  bit            m_pend = 1'b0;
  int            m_pval = 0;
  bit            m_ack  = 1'b0;
  bit            m_live = 1'b0;
  logic [CH-1:0] last_out;
  int            ack_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [CH-1:0] exp_out(input logic [CH-1:0] in);
    return (m_cur == 0) ? in : m_hist[m_cur-1];
  endfunction

  task automatic model_edge(input logic r, input logic [CH-1:0] in, input logic we,
                            input logic [DW-1:0] dv);
    bit quiet;
    int cv;
    if (!r) begin
      foreach (m_hist[k]) m_hist[k] = '0;
      m_cur  = RST_DELAY;
      m_pend = 1'b0;
      m_pval = 0;
      m_ack  = 1'b0;
      m_live = 1'b1;
      return;
    end
    quiet = 1'b1;
    foreach (m_hist[k]) if (m_hist[k] !== in) quiet = 1'b0;
    cv = (int'(dv) > DEPTH) ? DEPTH : int'(dv);
    m_ack = 1'b0;
    if (we) begin
      m_pval = cv;
      m_pend = 1'b1;
    end else if (m_pend && quiet) begin
      m_cur  = m_pval;
      m_pend = 1'b0;
      m_ack  = 1'b1;
    end
    for (int k = DEPTH - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = in;
  endtask

  task automatic cycle(input logic r, input logic [CH-1:0] in, input logic we,
                       input logic [DW-1:0] dv);
    rst = r; inR = in; cfg_we = we; cfg_delay = dv;
    #1;
    last_out = outR;
    if (cfg_ack === 1'b1) ack_cnt++;
    if (m_live) begin
      chk("outR", 32'(outR), 32'(exp_out(in)));
      chk("cur_delay", 32'(cur_delay), 32'(m_cur));
      chk("cfg_pending", 32'(cfg_pending), 32'(m_pend));
      chk("cfg_ack", 32'(cfg_ack), 32'(m_ack));
    end
    @(posedge clk);
    model_edge(r, in, we, dv);
    @(negedge clk);
  endtask

  task automatic hold(input logic [CH-1:0] in, input int n);
    for (int k = 0; k < n; k++) cycle(1'b1, in, 1'b0, '0);
  endtask

  initial begin
    logic [CH-1:0] v;
    int edge_at;
    bit we;
    logic r;
    logic [DW-1:0] dv;

    // Reset and default 12-cycle latency on channel 0
    cycle(1'b0, '0, 1'b1, DW'(5));
    cycle(1'b0, '0, 1'b0, '0);
    chk("rst_cur", 32'(cur_delay), 32'(RST_DELAY));
    chk("rst_pending", 32'(cfg_pending), 32'd0);
    chk("rst_out", 32'(outR), 32'd0);
    hold('0, 3);
    edge_at = -1;
    for (int k = 0; k < 20; k++) begin
      cycle(1'b1, 4'b0001, 1'b0, '0);
      if (edge_at < 0 && last_out[0]) edge_at = k;
    end
    chk("latency_rst", 32'(edge_at), 32'd12);
    chk("other_ch_zero", 32'(last_out[3:1]), 32'd0);

    // Reconfigure while idle
    hold(4'b1010, 20);
    cycle(1'b1, 4'b1010, 1'b1, DW'(3));
    chk("pend_after_we", 32'(cfg_pending), 32'd1);
    cycle(1'b1, 4'b1010, 1'b0, '0);
    chk("ack_idle", 32'(cfg_ack), 32'd1);
    chk("pend_cleared", 32'(cfg_pending), 32'd0);
    chk("cur_3", 32'(cur_delay), 32'd3);
    edge_at = -1;
    for (int k = 0; k < 10; k++) begin
      cycle(1'b1, 4'b1000, 1'b0, '0);
      if (edge_at < 0 && !last_out[1]) edge_at = k;
    end
    chk("latency_3", 32'(edge_at), 32'd3);

    // In-flight hold with toggling channel 2
    cycle(1'b0, '0, 1'b0, '0);
    hold('0, 20);
    ack_cnt = 0;
    v = '0;
    edge_at = -1;
    for (int k = 0; k < 30; k++) begin
      if (k % 5 == 0) v ^= 4'b0100;
      cycle(1'b1, v, (k == 3), DW'(7));
      if (edge_at < 0 && last_out[2]) edge_at = k;
    end
    chk("old_latency", 32'(edge_at), 32'd12);
    chk("hold_pending", 32'(cfg_pending), 32'd1);
    chk("hold_no_ack", 32'(ack_cnt), 32'd0);
    hold(v, 20);
    chk("hold_ack_once", 32'(ack_cnt), 32'd1);
    chk("cur_7", 32'(cur_delay), 32'd7);

    // Clamp, then bypass
    cycle(1'b1, v, 1'b1, DW'(20));
    hold(v, 20);
    chk("cur_clamp", 32'(cur_delay), 32'(DEPTH));
    cycle(1'b1, v, 1'b1, '0);
    hold(v, 20);
    chk("cur_0", 32'(cur_delay), 32'd0);
    for (int k = 0; k < 8; k++) begin
      v = CH'($urandom_range(15));
      cycle(1'b1, v, 1'b0, '0);
      chk("bypass", 32'(last_out), 32'(v));
    end

    // Overwrite while pending: last write wins, single ack
    hold(v, 20);
    ack_cnt = 0;
    cycle(1'b1, v, 1'b1, DW'(5));
    cycle(1'b1, v, 1'b1, DW'(9));
    hold(v, 20);
    chk("overwrite_acks", 32'(ack_cnt), 32'd1);
    chk("cur_9", 32'(cur_delay), 32'd9);

    // Reset while pending discards the write
    ack_cnt = 0;
    cycle(1'b1, v, 1'b1, DW'(5));
    cycle(1'b0, v, 1'b0, '0);
    chk("rstpend_cur", 32'(cur_delay), 32'(RST_DELAY));
    chk("rstpend_pending", 32'(cfg_pending), 32'd0);
    hold(v, 20);
    chk("rstpend_no_ack", 32'(ack_cnt), 32'd0);
    chk("rstpend_cur_late", 32'(cur_delay), 32'(RST_DELAY));

    // Random traffic
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(7) == 0) v = CH'($urandom_range(15));
      we = ($urandom_range(19) == 0);
      dv = DW'($urandom_range(31));
      r  = ($urandom_range(299) != 0);
      cycle(r, v, we, dv);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/delay_line_prog.md
DELAY_LINE_PROG -- requirements
Module: delay_line_prog

Interface
REQ-001 The block SHALL have parameter CH, default 4, meaning the number of independent request channels.
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning the maximum delay in clock cycles (DEPTH >= 1).
REQ-003 The block SHALL have parameter RST_DELAY, default 12, meaning the active delay after reset; it SHALL be 0..DEPTH.
REQ-004 The block SHALL define derived width DW = clog2(DEPTH+1).
REQ-005 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-006 rst  in  1  reset; it SHALL be synchronous and active-low.
REQ-007 inR  in  CH  request levels, one bit per channel.
REQ-008 outR  out  CH  delayed request levels.
REQ-009 cfg_delay  in  DW  requested delay value.
REQ-010 cfg_we  in  1  one-cycle strobe that captures cfg_delay.
REQ-011 cfg_pending  out  1  high while a captured value has not yet been applied.
REQ-012 cfg_ack  out  1  one-cycle pulse indicating that the new delay became active.
REQ-013 cur_delay  out  DW  currently active delay.

Function
REQ-014 Each channel c SHALL hold a DEPTH-stage shift register: stg[c][0] <= inR[c]; stg[c][i] <= stg[c][i-1].
REQ-015 For cur_delay = d >= 1, outR[c] SHALL equal stg[c][d-1], giving exactly d cycles of latency.
REQ-016 For cur_delay = 0, outR SHALL equal inR combinationally (bypass).
REQ-017 The shift registers SHALL continue to shift regardless of configuration state.
REQ-018 The write value SHALL be clamped: cfg_delay > DEPTH SHALL be captured as DEPTH.
REQ-019 The controller SHALL have two states, IDLE and PEND.
REQ-020 In IDLE, an edge with cfg_we=1 SHALL capture the clamped value into pend_val and move the controller to PEND.
REQ-021 Quiescent SHALL mean that, for every channel, all DEPTH stages equal the current inR, so no transition is in flight.
REQ-022 In PEND, at an edge where quiescent=1 and cfg_we=0:
- cur_delay <= pend_val
- the controller SHALL move to IDLE
- cfg_ack SHALL be 1 for the following cycle.
REQ-023 In PEND, cfg_we=1 SHALL overwrite pend_val and keep the controller in PEND; that edge SHALL NOT apply, and the last value written wins.
REQ-024 The earliest apply SHALL be the edge after the capturing edge, so there is at least one cycle of cfg_pending.
REQ-025 cfg_pending SHALL equal (state == PEND).
REQ-026 cfg_ack SHALL be registered and SHALL never be high for two consecutive cycles.
REQ-027 Writing a value equal to cur_delay SHALL still go through PEND and produce cfg_ack.
REQ-028 While non-quiescent, PEND SHALL persist indefinitely; there is no timeout.
REQ-029 Because the delay is only changed while quiescent, outR SHALL never glitch or drop or duplicate a transition.

Reset
REQ-030 When rst=0 at an edge, all stg bits SHALL be cleared to 0.
REQ-031 When rst=0 at an edge, cur_delay SHALL be set to RST_DELAY, the state to IDLE, pend_val to 0, and cfg_ack to 0.
REQ-032 Reset SHALL override cfg_we on the same edge.
REQ-033 Reset asserted while in PEND SHALL discard the pending value.
REQ-034 After reset, outR SHALL be 0; if RST_DELAY = 0, outR SHALL equal inR.
REQ-035 After rst returns to 1, the first cycle SHALL behave as normal operation.

Verification
REQ-036 Reset latency: defaults; after reset, toggle inR[0] 0->1 at cycle t -> outR[0] rises at cycle t+12, and other channels stay 0.
REQ-037 Reconfigure while idle: inR steady at 4'b1010 for more than 16 cycles, then cfg_we with cfg_delay=3 -> cfg_pending high for 1 cycle, cfg_ack the next cycle, cur_delay=3, and the next edge on inR[1] appears 3 cycles later.
REQ-038 In-flight hold: inR[2] toggles every 5 cycles, then cfg_we with cfg_delay=7 -> cfg_pending stays high until toggling stops and 16 steady cycles pass, then cfg_ack, and every toggle issued before the apply emerges with the old 12-cycle latency.
REQ-039 Clamp and bypass:
- cfg_delay=20 -> cur_delay=16 after ack.
- Then cfg_delay=0 -> outR tracks inR in the same cycle.
REQ-040 Overwrite and reset in PEND:
- cfg_we=5, then cfg_we=9 while in PEND -> a single cfg_ack with cur_delay=9.
- Repeat with rst=0 asserted while in PEND -> cur_delay=12, cfg_pending=0, and no cfg_ack.
